// File: rtl/pe_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pe_ctrl_pkg: shared state encoding and default widths for the PE row control.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pe_ctrl_pkg;

  localparam int DEF_MAX_CONFIG_WIDTH = 5;
  localparam int DEF_OUT_WIDTH        = 6;
  localparam int DEF_IF_ADDR_WIDTH    = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } pe_state_e;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_MAC  = MAC;
  localparam logic [1:0] ST_OUT  = OUT;
  localparam logic [1:0] ST_DONE = DONE;

endpackage

`default_nettype wire

// File: rtl/pe_tap_counter.sv
// ----------------------------------------------------------------------------
// pe_tap_counter: wrap-at-limit counter with synchronous clear; last flags count==limit.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pe_tap_counter
  import pe_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_MAX_CONFIG_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign last  = (count_q == limit);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = last ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pe_row_conv_ctrl.sv
// ----------------------------------------------------------------------------
// pe_row_conv_ctrl: sequences spad addresses / MAC enable for a 1-D row convolution.
// Optional macro PE_CTRL_STALL_EN adds the mac_stall input.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pe_row_conv_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int MAX_CONFIG_WIDTH = DEF_MAX_CONFIG_WIDTH,
  parameter int OUT_WIDTH        = DEF_OUT_WIDTH,
  parameter int IF_ADDR_WIDTH    = DEF_IF_ADDR_WIDTH
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic                        clear,
  input  logic [MAX_CONFIG_WIDTH-1:0] filter_size,
  input  logic [OUT_WIDTH-1:0]        num_outputs,
  input  logic                        psum_ready,
`ifdef PE_CTRL_STALL_EN
  input  logic                        mac_stall,
`endif
  output logic [MAX_CONFIG_WIDTH-1:0] filt_addr,
  output logic [IF_ADDR_WIDTH-1:0]    ifmap_addr,
  output logic                        mac_en,
  output logic                        acc_first,
  output logic                        psum_valid,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_err
);

  logic [1:0]                  state_q, state_d;
  logic [MAX_CONFIG_WIDTH-1:0] cfg_filter_size_q, cfg_filter_size_d;
  logic [OUT_WIDTH-1:0]        cfg_num_outputs_q, cfg_num_outputs_d;
  logic                        cfg_err_q, cfg_err_d;

  logic [MAX_CONFIG_WIDTH-1:0] tap;
  logic [OUT_WIDTH-1:0]        out_idx;
  logic                        tap_last;
  logic                        out_last;
  logic                        stall;

`ifdef PE_CTRL_STALL_EN
  assign stall = mac_stall;
`else
  assign stall = 1'b0;
`endif

  wire in_idle = (state_q == ST_IDLE);
  wire in_mac  = (state_q == ST_MAC);
  wire in_out  = (state_q == ST_OUT);
  wire in_done = (state_q == ST_DONE);

  // Tap restarts at 0 whenever the MAC phase is (re)entered.
  pe_tap_counter #(.WIDTH(MAX_CONFIG_WIDTH)) u_tap_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clear (clear || !in_mac),
    .inc   (in_mac && !stall),
    .limit (cfg_filter_size_q - MAX_CONFIG_WIDTH'(1)),
    .count (tap),
    .last  (tap_last)
  );

  pe_tap_counter #(.WIDTH(OUT_WIDTH)) u_out_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clear (clear || in_idle || in_done),
    .inc   (in_out && psum_ready),
    .limit (cfg_num_outputs_q - OUT_WIDTH'(1)),
    .count (out_idx),
    .last  (out_last)
  );

  always_comb begin
    state_d           = state_q;
    cfg_filter_size_d = cfg_filter_size_q;
    cfg_num_outputs_d = cfg_num_outputs_q;
    cfg_err_d         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((filter_size != '0) && (num_outputs != '0)) begin
            cfg_filter_size_d = filter_size;
            cfg_num_outputs_d = num_outputs;
            state_d           = ST_MAC;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_MAC: begin
        if (!stall && tap_last) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (psum_ready) begin
          state_d = out_last ? ST_DONE : ST_MAC;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (clear) begin
      state_d   = ST_IDLE;
      cfg_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q           <= ST_IDLE;
      cfg_filter_size_q <= '0;
      cfg_num_outputs_q <= '0;
      cfg_err_q         <= 1'b0;
    end else begin
      state_q           <= state_d;
      cfg_filter_size_q <= cfg_filter_size_d;
      cfg_num_outputs_q <= cfg_num_outputs_d;
      cfg_err_q         <= cfg_err_d;
    end
  end

  // Address width is at least one bit wider than either operand, so the sum cannot wrap.
  assign filt_addr  = tap;
  assign ifmap_addr = IF_ADDR_WIDTH'(out_idx) + IF_ADDR_WIDTH'(tap);
  assign mac_en     = in_mac && !stall;
  assign acc_first  = in_mac && !stall && (tap == '0);
  assign psum_valid = in_out;
  assign busy       = !in_idle;
  assign done       = in_done;
  assign cfg_err    = cfg_err_q;

endmodule

`default_nettype wire

// File: tb/tb_pe_row_conv_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pe_row_conv_ctrl: directed self-checking bench for pe_row_conv_ctrl.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pe_row_conv_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       clear;
  logic [4:0] filter_size;
  logic [5:0] num_outputs;
  logic       psum_ready;
  logic       mac_stall;
  logic [4:0] filt_addr;
  logic [6:0] ifmap_addr;
  logic       mac_en, acc_first, psum_valid, busy, done, cfg_err;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  bit          rdy_q[$];
  bit          stl_q[$];

  wire [15:0] obs_vec = {mac_en, acc_first, psum_valid, done, filt_addr, ifmap_addr};

  always #5 clk = ~clk;

  pe_row_conv_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .clear       (clear),
    .filter_size (filter_size),
    .num_outputs (num_outputs),
    .psum_ready  (psum_ready),
`ifdef PE_CTRL_STALL_EN
    .mac_stall   (mac_stall),
`endif
    .filt_addr   (filt_addr),
    .ifmap_addr  (ifmap_addr),
    .mac_en      (mac_en),
    .acc_first   (acc_first),
    .psum_valid  (psum_valid),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] v(input bit me, input bit af, input bit pv, input bit dn,
                                    input int fa, input int ia);
    v = {me, af, pv, dn, fa[4:0], ia[6:0]};
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic start_row(input int fs, input int no);
    start       = 1'b1;
    filter_size = fs[4:0];
    num_outputs = no[5:0];
    next();
    start = 1'b0;
  endtask

  // One expected vector per cycle; inputs at edge+1, sampling at edge+2.
  task automatic expect_seq(input string tag);
    for (int k = 0; k < exp_q.size(); k++) begin
      psum_ready = rdy_q[k];
      mac_stall  = stl_q[k];
      #1;
      check($sformatf("%s[%0d]", tag, k), 32'(obs_vec), 32'(exp_q[k]));
      next();
    end
    mac_stall = 1'b0;
  endtask

  initial begin
    int cyc, macs, last_if, max_if, done_cyc;
    bit seen_done;

    rstn = 1'b0; start = 1'b0; clear = 1'b0; filter_size = '0; num_outputs = '0;
    psum_ready = 1'b0; mac_stall = 1'b0;
    repeat (3) next();
    #1;
    check("reset_vec", 32'(obs_vec), 32'h0);
    check("reset_flags", {29'd0, busy, cfg_err, done}, 32'h0);
    rstn = 1'b1;
    next();

    // Basic row, config inputs changed after start must not matter.
    psum_ready = 1'b1;
    start_row(3, 2);
    filter_size = 5'd7;
    num_outputs = 6'd9;
    exp_q = '{v(1,1,0,0,0,0), v(1,0,0,0,1,1), v(1,0,0,0,2,2), v(0,0,1,0,0,0),
              v(1,1,0,0,0,1), v(1,0,0,0,1,2), v(1,0,0,0,2,3), v(0,0,1,0,0,1),
              v(0,0,0,1,0,0), v(0,0,0,0,0,0)};
    rdy_q = '{1,1,1,1,1,1,1,1,1,1};
    stl_q = '{0,0,0,0,0,0,0,0,0,0};
    expect_seq("row3x2");
    #1 check("row3x2_busy_end", 32'(busy), 32'd0);
    next();

    // Back-pressure: ready low 5 cycles on first psum.
    psum_ready = 1'b0;
    start_row(2, 2);
    exp_q = '{v(1,1,0,0,0,0), v(1,0,0,0,1,1), v(0,0,1,0,0,0), v(0,0,1,0,0,0),
              v(0,0,1,0,0,0), v(0,0,1,0,0,0), v(0,0,1,0,0,0), v(0,0,1,0,0,0),
              v(1,1,0,0,0,1), v(1,0,0,0,1,2), v(0,0,1,0,0,1), v(0,0,0,1,0,0)};
    rdy_q = '{0,0,0,0,0,0,0,1,1,1,1,1};
    stl_q = '{0,0,0,0,0,0,0,0,0,0,0,0};
    expect_seq("bp");
    next();

    // Rejected configurations.
    start_row(0, 2);
    #1;
    check("cfgerr_fs0", {30'd0, cfg_err, busy}, 32'h2);
    next();
    #1;
    check("cfgerr_fs0_after", {30'd0, cfg_err, busy}, 32'h0);
    next();
    start_row(3, 0);
    #1;
    check("cfgerr_no0", {30'd0, cfg_err, busy}, 32'h2);
    next();
    #1;
    check("cfgerr_no0_after", {30'd0, cfg_err, busy}, 32'h0);
    next();

    // Clear mid-MAC at tap 2, then restart.
    psum_ready = 1'b1;
    start_row(5, 2);
    next();
    next();
    #1;
    check("clr_pre", 32'(obs_vec), 32'(v(1,0,0,0,2,2)));
    clear = 1'b1;
    next();
    clear = 1'b0;
    #1;
    check("clr_vec", 32'(obs_vec), 32'h0);
    check("clr_flags", {29'd0, busy, cfg_err, done}, 32'h0);
    next();
    start_row(5, 2);
    #1;
    check("clr_restart", 32'(obs_vec), 32'(v(1,1,0,0,0,0)));
    check("clr_restart_busy", 32'(busy), 32'd1);
    clear = 1'b1;
    next();
    clear = 1'b0;

    // Maximum configuration, with an ignored start pulse mid-row.
    psum_ready = 1'b1;
    start_row(31, 63);
    cyc = 0; macs = 0; last_if = 0; max_if = 0; done_cyc = -1; seen_done = 1'b0;
    while (!seen_done && cyc < 3000) begin
      start = (cyc == 100);
      if (cyc == 100) begin
        filter_size = 5'd1;
        num_outputs = 6'd1;
      end
      #1;
      if (done) begin
        seen_done = 1'b1;
        done_cyc  = cyc;
      end else begin
        if (mac_en) begin
          macs++;
          last_if = int'(ifmap_addr);
          if (int'(ifmap_addr) > max_if) max_if = int'(ifmap_addr);
        end
        next();
        cyc++;
      end
    end
    start = 1'b0;
    check("max_done_seen", 32'(seen_done), 32'd1);
    check("max_done_cycle", 32'(done_cyc), 32'd2016);
    check("max_mac_count", 32'(macs), 32'd1953);
    check("max_last_ifmap", 32'(last_if), 32'd92);
    check("max_peak_ifmap", 32'(max_if), 32'd92);
    next();
    #1;
    check("max_idle_after", 32'(busy), 32'd0);
    next();

`ifdef PE_CTRL_STALL_EN
    // Stall held 3 cycles at tap 1 extends MAC by 3 cycles.
    psum_ready = 1'b1;
    start_row(3, 1);
    exp_q = '{v(1,1,0,0,0,0), v(0,0,0,0,1,1), v(0,0,0,0,1,1), v(0,0,0,0,1,1),
              v(1,0,0,0,1,1), v(1,0,0,0,2,2), v(0,0,1,0,0,0), v(0,0,0,1,0,0)};
    rdy_q = '{1,1,1,1,1,1,1,1};
    stl_q = '{0,1,1,1,0,0,0,0};
    expect_seq("stall");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
